// File: rtl/tap_ctrl.sv
// ---------------------------------------------------------------------------
// tap_ctrl -- IEEE 1149.1 style Test Access Port controller.
//
// A 16-state TAP FSM clocked by TCK, plus the instruction register and
// the two internal data registers (1-bit bypass and 32-bit IDCODE). The
// boundary-scan chain itself lives outside; this block selects it and
// muxes its serial output onto TDO.
//
// Ports
//   TCK        in   sole clock, all state updates on its rising edge
//   TRST       in   synchronous active-high reset (wins over TMS/TDI)
//   TMS        in   test mode select, steers the FSM
//   TDI        in   serial data in
//   bsr_tdo    in   serial out of the external boundary-scan chain
//   TDO        out  serial data out (0 outside the shift states)
//   tdo_en     out  high in SHIFT_DR or SHIFT_IR
//   tap_state  out  current FSM state code
//   dr_capture out  state is CAPTURE_DR
//   dr_shift   out  state is SHIFT_DR
//   dr_update  out  state is UPDATE_DR
//   bsr_select out  active instruction targets the boundary-scan chain
//   mode       out  boundary cells drive pins from their update latches
//   instr      out  active instruction
// ---------------------------------------------------------------------------
module tap_ctrl #(
   parameter int unsigned IR_WIDTH   = 4,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
   input  logic                TCK,
   input  logic                TRST,
   input  logic                TMS,
   input  logic                TDI,
   input  logic                bsr_tdo,
   output logic                TDO,
   output logic                tdo_en,
   output logic [3:0]          tap_state,
   output logic                dr_capture,
   output logic                dr_shift,
   output logic                dr_update,
   output logic                bsr_select,
   output logic                mode,
   output logic [IR_WIDTH-1:0] instr
);

   // State codes are the conventional 1149.1 encoding so tap_state can be
   // compared directly against external debugger traces.
   typedef enum logic [3:0] {
      TLR      = 4'hF,
      RTI      = 4'hC,
      SEL_DR   = 4'h7,
      CAP_DR   = 4'h6,
      SH_DR    = 4'h2,
      EX1_DR   = 4'h1,
      PAUSE_DR = 4'h3,
      EX2_DR   = 4'h0,
      UPD_DR   = 4'h5,
      SEL_IR   = 4'h4,
      CAP_IR   = 4'hE,
      SH_IR    = 4'hA,
      EX1_IR   = 4'h9,
      PAUSE_IR = 4'hB,
      EX2_IR   = 4'h8,
      UPD_IR   = 4'hD
   } tap_state_e;

   localparam logic [IR_WIDTH-1:0] I_EXTEST  = '0;
   localparam logic [IR_WIDTH-1:0] I_IDCODE  = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] I_SAMPLE  = IR_WIDTH'(2);
   // Value captured into the IR shift register: the mandatory "01" pattern.
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

   tap_state_e          state_q, state_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic [IR_WIDTH-1:0] instr_q, instr_d;
   logic                byp_q, byp_d;
   logic [31:0]         idcode_q, idcode_d;

   // ------------------------------------------------------------------
   // Instruction decode. Anything that is not EXTEST, IDCODE or
   // SAMPLE/PRELOAD falls through to BYPASS, including all-ones.
   // ------------------------------------------------------------------
   logic is_extest, is_sample, is_idcode, is_bsr, is_bypass;

   always_comb begin
      is_extest = (instr_q == I_EXTEST);
      is_sample = (instr_q == I_SAMPLE);
      is_idcode = (instr_q == I_IDCODE);
      is_bsr    = is_extest | is_sample;
      is_bypass = ~is_bsr & ~is_idcode;
   end

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge TCK) begin
      if (TRST) state_q <= TLR;
      else      state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // FSM next state. The IR column mirrors the DR column; SEL_IR with
   // TMS=1 is the only exit back to TLR, which is what makes five TMS=1
   // edges reach TLR from anywhere.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TLR:      state_d = TMS ? TLR      : RTI;
         RTI:      state_d = TMS ? SEL_DR   : RTI;
         SEL_DR:   state_d = TMS ? SEL_IR   : CAP_DR;
         CAP_DR:   state_d = TMS ? EX1_DR   : SH_DR;
         SH_DR:    state_d = TMS ? EX1_DR   : SH_DR;
         EX1_DR:   state_d = TMS ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: state_d = TMS ? EX2_DR   : PAUSE_DR;
         EX2_DR:   state_d = TMS ? UPD_DR   : SH_DR;
         UPD_DR:   state_d = TMS ? SEL_DR   : RTI;
         SEL_IR:   state_d = TMS ? TLR      : CAP_IR;
         CAP_IR:   state_d = TMS ? EX1_IR   : SH_IR;
         SH_IR:    state_d = TMS ? EX1_IR   : SH_IR;
         EX1_IR:   state_d = TMS ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: state_d = TMS ? EX2_IR   : PAUSE_IR;
         EX2_IR:   state_d = TMS ? UPD_IR   : SH_IR;
         UPD_IR:   state_d = TMS ? SEL_DR   : RTI;
         default:  state_d = TLR;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath next-state. Every register holds unless the current state
   // addresses it; PAUSE/EXIT states therefore leave all shifters alone.
   // ------------------------------------------------------------------
   always_comb begin
      ir_d     = ir_q;
      instr_d  = instr_q;
      byp_d    = byp_q;
      idcode_d = idcode_q;

      unique case (state_q)
         TLR: begin
            // Sitting in TLR keeps re-selecting IDCODE, so a debugger
            // always finds a known instruction after a TMS reset.
            instr_d = I_IDCODE;
         end
         CAP_IR: begin
            ir_d = IR_CAPTURE;
         end
         SH_IR: begin
            ir_d = {TDI, ir_q[IR_WIDTH-1:1]};
         end
         UPD_IR: begin
            instr_d = ir_q;
         end
         CAP_DR: begin
            if (is_idcode) idcode_d = IDCODE_VAL;
            if (is_bypass) byp_d    = 1'b0;
         end
         SH_DR: begin
            if (is_idcode) idcode_d = {TDI, idcode_q[31:1]};
            if (is_bypass) byp_d    = TDI;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers. A reset mid-shift simply overwrites whatever
   // partial contents the shifters held.
   // ------------------------------------------------------------------
   always_ff @(posedge TCK) begin
      if (TRST) begin
         ir_q     <= '0;
         instr_q  <= I_IDCODE;
         byp_q    <= 1'b0;
         idcode_q <= IDCODE_VAL;
      end else begin
         ir_q     <= ir_d;
         instr_q  <= instr_d;
         byp_q    <= byp_d;
         idcode_q <= idcode_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: pure Moore decodes of the registered state, no extra
   // pipeline stage.
   // ------------------------------------------------------------------
   always_comb begin
      tap_state  = state_q;
      dr_capture = (state_q == CAP_DR);
      dr_shift   = (state_q == SH_DR);
      dr_update  = (state_q == UPD_DR);
      tdo_en     = (state_q == SH_DR) | (state_q == SH_IR);
      bsr_select = is_bsr;
      mode       = is_extest;
      instr      = instr_q;
   end

   // TDO mux. The external chain's output is passed straight through, so
   // TDO is combinational from registered state plus bsr_tdo.
   always_comb begin
      TDO = 1'b0;
      if (state_q == SH_IR) begin
         TDO = ir_q[0];
      end else if (state_q == SH_DR) begin
         if (is_bsr)         TDO = bsr_tdo;
         else if (is_idcode) TDO = idcode_q[0];
         else                TDO = byp_q;
      end
   end

endmodule

// File: tb/tb_tap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tap_ctrl -- self-checking bench for tap_ctrl.
// A table-driven reference model (next-state lookup, integer registers)
// predicts every output each cycle; directed sequences add end-to-end
// checks on serial streams and instruction effects, then a random TMS/TDI
// walk with occasional resets and five-ones escapes.
// ---------------------------------------------------------------------------
module tb_tap_ctrl;
   localparam int          IRW = 4;
   localparam logic [31:0] IDV = 32'h1000_0001;

   logic           TCK = 1'b0;
   logic           TRST, TMS, TDI, bsr_tdo;
   logic           TDO, tdo_en, dr_capture, dr_shift, dr_update;
   logic           bsr_select, mode;
   logic [3:0]     tap_state;
   logic [IRW-1:0] instr;

   tap_ctrl #(.IR_WIDTH(IRW), .IDCODE_VAL(IDV)) dut (
      .TCK        (TCK),
      .TRST       (TRST),
      .TMS        (TMS),
      .TDI        (TDI),
      .bsr_tdo    (bsr_tdo),
      .TDO        (TDO),
      .tdo_en     (tdo_en),
      .tap_state  (tap_state),
      .dr_capture (dr_capture),
      .dr_shift   (dr_shift),
      .dr_update  (dr_update),
      .bsr_select (bsr_select),
      .mode       (mode),
      .instr      (instr)
   );

   always #5 TCK = ~TCK;

   int vectors     = 0;
   int miscompares = 0;

   // reference model
   int          nxt0[16], nxt1[16];
   int          m_state, m_instr, m_ir;
   logic        m_byp;
   logic [31:0] m_id;

   // last sampled DUT outputs (taken before the edge of each step)
   logic [3:0]     o_state;
   logic [IRW-1:0] o_instr;
   logic           o_tdo, o_cap, o_bsr, o_mode;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic init_fsm();
      // state: TMS=0 / TMS=1
      nxt0[4'hF] = 4'hC; nxt1[4'hF] = 4'hF;
      nxt0[4'hC] = 4'hC; nxt1[4'hC] = 4'h7;
      nxt0[4'h7] = 4'h6; nxt1[4'h7] = 4'h4;
      nxt0[4'h6] = 4'h2; nxt1[4'h6] = 4'h1;
      nxt0[4'h2] = 4'h2; nxt1[4'h2] = 4'h1;
      nxt0[4'h1] = 4'h3; nxt1[4'h1] = 4'h5;
      nxt0[4'h3] = 4'h3; nxt1[4'h3] = 4'h0;
      nxt0[4'h0] = 4'h2; nxt1[4'h0] = 4'h5;
      nxt0[4'h5] = 4'hC; nxt1[4'h5] = 4'h7;
      nxt0[4'h4] = 4'hE; nxt1[4'h4] = 4'hF;
      nxt0[4'hE] = 4'hA; nxt1[4'hE] = 4'h9;
      nxt0[4'hA] = 4'hA; nxt1[4'hA] = 4'h9;
      nxt0[4'h9] = 4'hB; nxt1[4'h9] = 4'hD;
      nxt0[4'hB] = 4'hB; nxt1[4'hB] = 4'h8;
      nxt0[4'h8] = 4'hA; nxt1[4'h8] = 4'hD;
      nxt0[4'hD] = 4'hC; nxt1[4'hD] = 4'h7;
   endtask

   function automatic bit m_is_bsr();
      return (m_instr == 0) || (m_instr == 2);
   endfunction

   function automatic bit m_is_byp();
      return !m_is_bsr() && (m_instr != 1);
   endfunction

   task automatic model_edge(input logic trst, input logic tms, input logic tdi);
      if (trst) begin
         m_state = 4'hF; m_instr = 1; m_ir = 0; m_byp = 1'b0; m_id = IDV;
      end else begin
         case (m_state)
            4'h6: begin
               if (m_instr == 1) m_id = IDV;
               else if (m_is_byp()) m_byp = 1'b0;
            end
            4'h2: begin
               if (m_instr == 1) m_id = {tdi, m_id[31:1]};
               else if (m_is_byp()) m_byp = tdi;
            end
            4'hE: m_ir = 1;
            4'hA: m_ir = (m_ir >> 1) | (int'(tdi) << (IRW - 1));
            4'hD: m_instr = m_ir;
            4'hF: m_instr = 1;
            default: ;
         endcase
         m_state = tms ? nxt1[m_state] : nxt0[m_state];
      end
   endtask

   // One TCK cycle: drive at negedge, compare everything against the model,
   // then let the rising edge happen and advance the model.
   task automatic step(input logic trst, input logic tms, input logic tdi, input logic bsr);
      logic e_tdo;
      @(negedge TCK);
      TRST = trst; TMS = tms; TDI = tdi; bsr_tdo = bsr;
      #1;
      o_state = tap_state; o_instr = instr; o_tdo = TDO;
      o_cap = dr_capture; o_bsr = bsr_select; o_mode = mode;
      e_tdo = 1'b0;
      if (m_state == 4'hA)      e_tdo = m_ir[0];
      else if (m_state == 4'h2) e_tdo = m_is_bsr() ? bsr : (m_instr == 1) ? m_id[0] : m_byp;
      chk("tap_state",  32'(tap_state),  32'(m_state));
      chk("instr",      32'(instr),      32'(m_instr));
      chk("tdo",        32'(TDO),        32'(e_tdo));
      chk("tdo_en",     32'(tdo_en),     32'((m_state == 4'h2) || (m_state == 4'hA)));
      chk("dr_capture", 32'(dr_capture), 32'(m_state == 4'h6));
      chk("dr_shift",   32'(dr_shift),   32'(m_state == 4'h2));
      chk("dr_update",  32'(dr_update),  32'(m_state == 4'h5));
      chk("bsr_select", 32'(bsr_select), 32'(m_is_bsr()));
      chk("mode",       32'(mode),       32'(m_instr == 0));
      @(posedge TCK);
      model_edge(trst, tms, tdi);
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // RTI -> shift `code` into IR (LSB first) -> UPD_IR -> RTI.
   task automatic load_ir(input logic [IRW-1:0] code, output logic [IRW-1:0] seen);
      step(0, 1, rb(), rb()); step(0, 1, rb(), rb());
      step(0, 0, rb(), rb()); step(0, 0, rb(), rb());
      for (int i = 0; i < IRW; i++) begin
         step(0, i == IRW - 1, code[i], rb());
         seen[i] = o_tdo;
      end
      step(0, 1, rb(), rb()); step(0, 0, rb(), rb());
   endtask

   // RTI -> SEL_DR -> CAP_DR -> SH_DR (arrives in SH_DR)
   task automatic go_shdr();
      step(0, 1, rb(), rb()); step(0, 0, rb(), rb()); step(0, 0, rb(), rb());
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [IRW-1:0] seen;
      logic [31:0]    idbits;
      logic [3:0]     bpbits;
      int             ncap;

      init_fsm();
      TRST = 1'b1; TMS = 1'b0; TDI = 1'b0; bsr_tdo = 1'b0;
      repeat (2) @(posedge TCK);
      model_edge(1, 0, 0);

      // TMS 0,1,0,0 from TLR walks RTI, SEL_DR, CAP_DR, SH_DR
      ncap = 0;
      step(0, 0, 0, 0); chk("tlr_start", 32'(o_state), 32'hF);
      step(0, 1, 0, 0); chk("walk_rti",  32'(o_state), 32'hC); ncap += int'(o_cap);
      step(0, 0, 0, 0); chk("walk_sdr",  32'(o_state), 32'h7); ncap += int'(o_cap);
      step(0, 0, 0, 0); chk("walk_cdr",  32'(o_state), 32'h6); ncap += int'(o_cap);
      step(0, 1, 1, 0); chk("walk_shdr", 32'(o_state), 32'h2); ncap += int'(o_cap);
      step(0, 1, 0, 0); ncap += int'(o_cap);
      step(0, 0, 0, 0); ncap += int'(o_cap);
      chk("dr_capture_once", 32'(ncap), 32'd1);

      // reset mid-shift, TMS/TDI pulling the other way
      go_shdr();
      step(0, 0, 1, 1); step(0, 0, 1, 1);
      step(1, 0, 1, 1);
      step(0, 1, 0, 0);
      chk("rst_state", 32'(o_state), 32'hF);
      chk("rst_instr", 32'(o_instr), 32'd1);
      chk("rst_tdo",   32'(o_tdo),   32'd0);
      chk("rst_cap",   32'(o_cap),   32'd0);
      chk("rst_bsr",   32'(o_bsr),   32'd0);
      chk("rst_mode",  32'(o_mode),  32'd0);

      // IDCODE streamed LSB first right after reset
      step(0, 0, rb(), rb());
      go_shdr();
      for (int i = 0; i < 32; i++) begin
         step(0, i == 31, rb(), rb());
         idbits[i] = o_tdo;
      end
      chk("idcode_stream", idbits, 32'h1000_0001);
      step(0, 1, 0, 0); step(0, 0, 0, 0);

      // EXTEST
      load_ir(4'b0000, seen);
      chk("ir_capture_stream", 32'(seen), 32'b0001);
      step(0, 0, 0, 0);
      chk("extest_instr", 32'(o_instr), 32'd0);
      chk("extest_bsr",   32'(o_bsr),   32'd1);
      chk("extest_mode",  32'(o_mode),  32'd1);

      // five TMS=1 from SH_DR while EXTEST is active
      go_shdr();
      for (int i = 0; i < 5; i++) step(0, 1, rb(), rb());
      step(0, 1, 0, 0);
      chk("escape_state", 32'(o_state), 32'hF);
      step(0, 0, 0, 0);
      chk("escape_instr", 32'(o_instr), 32'd1);

      // unused code behaves as BYPASS
      load_ir(4'b0111, seen);
      step(0, 0, 0, 0);
      chk("unused_instr", 32'(o_instr), 32'h7);
      chk("unused_bsr",   32'(o_bsr),   32'd0);
      go_shdr();
      step(0, 0, 1, 1); bpbits[0] = o_tdo;
      step(0, 0, 0, 1); bpbits[1] = o_tdo;
      step(0, 0, 1, 0); bpbits[2] = o_tdo;
      step(0, 1, 0, 0); bpbits[3] = o_tdo;
      chk("bypass_stream", 32'(bpbits), 32'b1010);
      step(0, 1, 0, 0); step(0, 0, 0, 0);

      // random walk
      for (int n = 0; n < 1500; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            step(1, rb(), rb(), rb());
         end else if (r < 4) begin
            for (int k = 0; k < 5; k++) step(0, 1, rb(), rb());
            step(0, rb(), rb(), rb());
            chk("rand_escape", 32'(o_state), 32'hF);
         end else begin
            step(0, 1'($urandom_range(0, 9) < 4), rb(), rb());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tap_ctrl.md
TAP_CTRL -- requirements
Module: tap_ctrl

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction register width; SHALL be at least 2.
REQ-002 Parameter IDCODE_VAL, default 32'h1000_0001: device ID; bit 0 SHALL be 1.
REQ-003 Ports SHALL be:
- TCK  in  1  sole clock; every register updates on its rising edge.
- TRST  in  1  reset; synchronous, active-high.
- TMS  in  1  test mode select.
- TDI  in  1  serial data in.
- bsr_tdo  in  1  serial out of the boundary scan register chain.
- TDO  out  1  serial data out.
- tdo_en  out  1  high in SHIFT_DR or SHIFT_IR.
- tap_state  out  4  current state code.
- dr_capture  out  1  state is CAPTURE_DR.
- dr_shift  out  1  state is SHIFT_DR.
- dr_update  out  1  state is UPDATE_DR.
- bsr_select  out  1  current instruction selects the BSR.
- mode  out  1  BSR control mode (drives pins from update cells).
- instr  out  IR_WIDTH  active instruction.

Function
REQ-004 The 16-state TAP FSM SHALL use these codes: TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAUSE_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAUSE_IR=B, EX2_IR=8, UPD_IR=D.
REQ-005 Transitions SHALL be, written as state: TMS=0 -> / TMS=1 ->:
- TLR: RTI / TLR
- RTI: RTI / SEL_DR
- SEL_DR: CAP_DR / SEL_IR
- CAP_DR: SH_DR / EX1_DR
- SH_DR: SH_DR / EX1_DR
- EX1_DR: PAUSE_DR / UPD_DR
- PAUSE_DR: PAUSE_DR / EX2_DR
- EX2_DR: SH_DR / UPD_DR
- UPD_DR: RTI / SEL_DR
- SEL_IR: CAP_IR / TLR
- The IR states SHALL mirror the DR states.
REQ-006 From any state, 5 consecutive TCK edges with TMS=1 SHALL reach TLR.
REQ-007 dr_capture, dr_shift, dr_update and tdo_en SHALL be Moore decodes of the current state, with no added latency.
REQ-008 Instruction codes SHALL be: EXTEST=0, IDCODE=1, SAMPLE_PRELOAD=2, BYPASS=all ones; every other code SHALL behave as BYPASS.
REQ-009 IR shift register, on an edge in CAP_IR: SHALL load the value 1 (LSBs 01, other bits 0).
REQ-010 IR shift register, on an edge in SH_IR: SHALL shift right, with TDI entering the MSB.
REQ-011 instr SHALL load the IR shift register on the edge taken while in UPD_IR; the new value is visible the following cycle.
REQ-012 instr SHALL be forced to IDCODE on every edge taken while in TLR.
REQ-013 The bypass register (1 bit) SHALL load 0 on CAP_DR and load TDI on SH_DR, only when the decoded instruction is BYPASS.
REQ-014 The IDCODE register (32 bits) SHALL load IDCODE_VAL on CAP_DR and shift right with TDI into bit 31 on SH_DR, only when instr=IDCODE.
REQ-015 bsr_select SHALL be 1 iff instr is EXTEST or SAMPLE_PRELOAD.
REQ-016 mode SHALL be 1 iff instr is EXTEST.
REQ-017 TDO selection SHALL be:
- SH_IR: ir_shift[0].
- SH_DR with bsr_select: bsr_tdo.
- SH_DR with IDCODE: idcode_sr[0].
- SH_DR with BYPASS: bypass bit.
- Any other state: 0.
TDO SHALL be combinational from registered state.
REQ-018 Registers not addressed in the current state SHALL hold their value.
REQ-019 PAUSE and EXIT states SHALL hold all shift registers unchanged.

Reset
REQ-020 When TRST=1 at a rising TCK edge, the block SHALL take these values after that edge:
- state=TLR
- instr=IDCODE
- ir_shift=0
- bypass=0
- idcode_sr=IDCODE_VAL
REQ-021 TRST SHALL override TMS and TDI.
REQ-022 TRST asserted mid-shift SHALL discard the partial shift.
REQ-023 Outputs after reset SHALL be: tap_state=F; tdo_en, TDO, dr_*, bsr_select and mode all 0.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- TRST=1 for one edge -> tap_state=F, instr=1, all strobes 0.
- TMS sequence 0,1,0,0 from TLR -> states RTI, SEL_DR, CAP_DR, SH_DR; dr_capture high exactly one cycle.
- Load EXTEST by shifting IR bits 0,0,0,0 then UPD_IR -> instr=0, bsr_select=1, mode=1 the cycle after UPD_IR; TDO during SH_IR emits 1,0,0,0.
- IDCODE after reset: CAP_DR then 32 SH_DR cycles -> TDO emits 32'h1000_0001 LSB first.
- Load instruction 4'b0111 (unused) -> behaves as BYPASS; TDI pattern 1,0,1 in SH_DR appears on TDO one cycle later, preceded by captured 0.
- Mid-state SH_DR with TMS=1 for 5 edges -> TLR reached; instr forced to 1 regardless of previous EXTEST.
